// File: rtl/mdio_pkg.sv
// Shared constants and the state type for the Clause 22 MDIO responder.
package mdio_pkg;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RD_DATA,
    S_WR_DATA
  } mdio_state_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronisers for MDC/MDIO plus registered MDC rise/fall pulses.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_mdc_rise,
  output logic o_mdc_fall,
  output logic o_mdio
);

  logic [1:0] r_mdc_sync;
  logic [1:0] r_mdio_sync;
  logic       r_mdc_prev;
  logic       r_rise;
  logic       r_fall;
  logic       r_mdio_smp;

  // MDIO is delayed by one extra stage so it lines up with the edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_sync  <= 2'b00;
      r_mdio_sync <= 2'b11;
      r_mdc_prev  <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_mdio_smp  <= 1'b1;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
      r_mdio_sync <= {r_mdio_sync[0], i_mdio};
      r_mdc_prev  <= r_mdc_sync[1];
      r_rise      <= r_mdc_sync[1] & ~r_mdc_prev;
      r_fall      <= ~r_mdc_sync[1] & r_mdc_prev;
      r_mdio_smp  <= r_mdio_sync[1];
    end
  end

  assign o_mdc_rise = r_rise;
  assign o_mdc_fall = r_fall;
  assign o_mdio     = r_mdio_smp;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side MDIO Clause 22 target: decodes frames for PHY_ADDR and drives a
// single-cycle register-file port; drives MDIO only for read TA bit 2 and data.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         PREAMBLE_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mdc_i,
  input  logic                mdio_i,
  output logic                mdio_o,
  output logic                mdio_t,
  output logic [REGAD_W-1:0]  reg_addr,
  output logic                reg_wr_en,
  output logic [DATA_W-1:0]   reg_wr_data,
  output logic                reg_rd_en,
  input  logic [DATA_W-1:0]   reg_rd_data,
  output logic                frame_err
);

  localparam int PRE_W = (PREAMBLE_BITS < 1) ? 1 : $clog2(PREAMBLE_BITS + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_BITS);

  logic w_rise;
  logic w_fall;
  logic w_mdio_smp;

  mdio_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mdc      (mdc_i),
    .i_mdio     (mdio_i),
    .o_mdc_rise (w_rise),
    .o_mdc_fall (w_fall),
    .o_mdio     (w_mdio_smp)
  );

  mdio_state_t         r_state,     w_state_next;
  logic [4:0]          r_bit_cnt,   w_cnt_next;
  logic [PRE_W-1:0]    r_pre_cnt,   w_pre_next;
  logic [DATA_W-1:0]   r_shift,     w_shift_next;
  logic                r_is_read,   w_is_read_next;
  logic [REGAD_W-1:0]  r_addr,      w_addr_next;
  logic [DATA_W-1:0]   r_wr_data,   w_wr_data_next;
  logic                r_wr_en,     w_wr_en_next;
  logic                r_rd_en,     w_rd_en_next;
  logic                r_frame_err, w_err_next;
  logic                r_mdio_o,    w_mdio_o_next;
  logic                r_mdio_t,    w_mdio_t_next;
  logic                r_rd_cap;
  logic [DATA_W-1:0]   w_shift_in;

  assign w_shift_in = {r_shift[DATA_W-2:0], w_mdio_smp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_pre_cnt   <= '0;
      r_shift     <= '0;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_t    <= 1'b1;
      r_rd_cap    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_cnt_next;
      r_pre_cnt   <= w_pre_next;
      r_shift     <= w_shift_next;
      r_is_read   <= w_is_read_next;
      r_addr      <= w_addr_next;
      r_wr_data   <= w_wr_data_next;
      r_wr_en     <= w_wr_en_next;
      r_rd_en     <= w_rd_en_next;
      r_frame_err <= w_err_next;
      r_mdio_o    <= w_mdio_o_next;
      r_mdio_t    <= w_mdio_t_next;
      r_rd_cap    <= r_rd_en;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_bit_cnt;
    w_pre_next     = r_pre_cnt;
    w_shift_next   = r_shift;
    w_is_read_next = r_is_read;
    w_addr_next    = r_addr;
    w_wr_data_next = r_wr_data;
    w_wr_en_next   = 1'b0;
    w_rd_en_next   = 1'b0;
    w_err_next     = 1'b0;
    w_mdio_o_next  = r_mdio_o;
    w_mdio_t_next  = r_mdio_t;

    // Register-file data arrives one clk after the read strobe.
    if (r_rd_cap) w_shift_next = reg_rd_data;

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          if (w_mdio_smp != ST[1]) begin
            if (r_pre_cnt < PRE_MAX) w_pre_next = r_pre_cnt + 1'b1;
          end else if (r_pre_cnt >= PRE_MAX) begin
            w_state_next = S_ST;
            w_pre_next   = '0;
          end else begin
            w_pre_next = '0;
          end
        end
      end

      S_ST: begin
        if (w_rise) begin
          w_cnt_next = '0;
          if (w_mdio_smp == ST[0]) begin
            w_state_next = S_OP;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end

      S_OP: begin
        if (w_rise) begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'd0) begin
            w_cnt_next = 5'd1;
          end else begin
            w_cnt_next = '0;
            if (w_shift_in[1:0] == OP_READ) begin
              w_is_read_next = 1'b1;
              w_state_next   = S_PHYAD;
            end else if (w_shift_in[1:0] == OP_WRITE) begin
              w_is_read_next = 1'b0;
              w_state_next   = S_PHYAD;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = S_IDLE;
            end
          end
        end
      end

      S_PHYAD: begin
        if (w_rise) begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'(PHYAD_W - 1)) begin
            w_cnt_next   = '0;
            // Frames for another PHY are dropped silently.
            w_state_next = (w_shift_in[PHYAD_W-1:0] == PHY_ADDR) ? S_REGAD : S_IDLE;
          end else begin
            w_cnt_next = r_bit_cnt + 5'd1;
          end
        end
      end

      S_REGAD: begin
        if (w_rise) begin
          w_addr_next = {r_addr[REGAD_W-2:0], w_mdio_smp};
          if (r_bit_cnt == 5'(REGAD_W - 1)) begin
            w_cnt_next   = '0;
            w_state_next = S_TA;
            w_rd_en_next = r_is_read;
          end else begin
            w_cnt_next = r_bit_cnt + 5'd1;
          end
        end
      end

      S_TA: begin
        if (r_is_read) begin
          if (w_rise) begin
            if (r_bit_cnt == 5'd0) begin
              w_cnt_next = 5'd1;
            end else begin
              w_cnt_next   = '0;
              w_state_next = S_RD_DATA;
            end
          end else if (w_fall && r_bit_cnt == 5'd1) begin
            w_mdio_t_next = 1'b0;
            w_mdio_o_next = 1'b0;
          end
        end else if (w_rise) begin
          if (r_bit_cnt == 5'd0) begin
            if (w_mdio_smp) begin
              w_cnt_next = 5'd1;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = S_IDLE;
            end
          end else begin
            w_cnt_next = '0;
            if (!w_mdio_smp) begin
              w_state_next = S_WR_DATA;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = S_IDLE;
            end
          end
        end
      end

      S_RD_DATA: begin
        // Count rises; each fall before the 16th rise shifts out the next bit.
        if (w_rise) begin
          if (r_bit_cnt != 5'(DATA_W)) w_cnt_next = r_bit_cnt + 5'd1;
        end else if (w_fall) begin
          if (r_bit_cnt == 5'(DATA_W)) begin
            w_mdio_t_next = 1'b1;
            w_mdio_o_next = 1'b1;
            w_cnt_next    = '0;
            w_state_next  = S_IDLE;
          end else begin
            w_mdio_t_next = 1'b0;
            w_mdio_o_next = r_shift[DATA_W-1];
            w_shift_next  = {r_shift[DATA_W-2:0], 1'b0};
          end
        end
      end

      S_WR_DATA: begin
        if (w_rise) begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'(DATA_W - 1)) begin
            w_wr_data_next = w_shift_in;
            w_wr_en_next   = 1'b1;
            w_cnt_next     = '0;
            w_state_next   = S_IDLE;
          end else begin
            w_cnt_next = r_bit_cnt + 5'd1;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign mdio_o      = r_mdio_o;
  assign mdio_t      = r_mdio_t;
  assign reg_addr    = r_addr;
  assign reg_wr_en   = r_wr_en;
  assign reg_wr_data = r_wr_data;
  assign reg_rd_en   = r_rd_en;
  assign frame_err   = r_frame_err;

endmodule
